memory_game_sequencer: RTL and testbench
========================================

Name: memory_game_sequencer

Overview:
- Play controller for the memory game. Sits above the sequence generator and its nine-register memory.
- Starts generation, then replays a growing prefix of the stored sequence to the display. Collects player guesses and compares each guess against memory.
- Advances the level or ends the game as win or lose.
- Reads memory through the generator's read-address/read-data mux; that path is combinational.

Parameters:
N_ITEMS, 9, sequence length and final level (1..15)
SHOW_TICKS, 50, tick pulses each value is shown
GAP_TICKS, 10, blank tick pulses after each shown value
TIMEOUT_TICKS, 255, tick pulses allowed between guesses before lose (8-bit counters)

Ports:
clock  in  1  system clock
Resetn  in  1  asynchronous active-low reset
tick  in  1  one-cycle time-base enable (e.g. 100 Hz strobe)
start  in  1  level-sampled start/restart request
gen_done  in  1  generator finished filling memory (level)
mem_data  in  4  memory read data for read_add, same cycle
guess  in  4  player value
guess_valid  in  1  one-cycle guess strobe
gen_start  out  1  one-cycle pulse to generator start
read_add  out  4  memory read address, registered
show_val  out  4  value to display; 0 when blank
show_en  out  1  display active
level  out  4  current level (number of items to recall)
score  out  4  levels fully completed
busy  out  1  high in any state except IDLE/WIN/LOSE
win  out  1  held high in WIN
lose  out  1  held high in LOSE

Behaviour:
- Reset (async, Resetn=0): state IDLE, read_add=0, show_val=0, show_en=0, level=0, score=0, gen_start=0, win=0, lose=0, tick and idx counters 0.
- All outputs are registered; state changes on the rising clock edge.
- IDLE / WIN / LOSE, start=1:
  - Clear score and win/lose; set level=1.
  - Pulse gen_start for exactly one cycle.
  - Go to WAIT_GEN.
  - Otherwise hold. start is ignored in every other state.
- WAIT_GEN: on gen_done=1, set idx=0 and go to SHOW. gen_done must not be sampled in the cycle gen_start is high.
- SHOW:
  - read_add=idx, show_en=1, show_val=mem_data registered each cycle.
  - Count tick pulses; after SHOW_TICKS ticks clear show_en and show_val, then go to GAP.
- GAP:
  - After GAP_TICKS ticks: idx++.
  - If idx==level, set idx=0, read_add=0 and go to INPUT.
  - Else go to SHOW.
- INPUT:
  - read_add=idx, show_en=0. Timeout counter is cleared on entry and on every accepted guess, and increments on tick.
  - guess_valid with guess==mem_data → correct:
    - If idx+1 < level: idx++.
    - Else score++, then:
      - If level==N_ITEMS, go to WIN.
      - Else level++, idx=0, go to SHOW.
  - guess_valid with guess!=mem_data → LOSE.
  - Timeout counter reaching TIMEOUT_TICKS → LOSE.
  - guess_valid and timeout in the same cycle: the guess has priority.
- guess_valid outside INPUT is ignored. tick outside SHOW/GAP/INPUT is ignored.
- Counters never wrap: level saturates at N_ITEMS, score at N_ITEMS.
- Reset mid-operation returns to IDLE immediately. The generator is not re-triggered until the next start.
- A one-cycle gap exists between accepting a correct guess and read_add updating. A second guess_valid in the cycle immediately after an accepted guess is ignored.

Test Plan:
- Reset, then start=1 for 1 cycle → gen_start high exactly 1 cycle, state WAIT_GEN, level=1; with gen_done held low the block stays in WAIT_GEN indefinitely.
- Memory preloaded 3,7,1,... with SHOW_TICKS=2, GAP_TICKS=1, gen_done=1 → show_en high for 2 ticks with show_val=3, blank for 1 tick, then INPUT with read_add=0.
- Level 1, guess 3 valid → score=1, level=2; replay shows 3 then 7; guesses 3,7 → score=2, level=3.
- Level 2, guesses 3 then 5 → lose=1, busy=0; a further guess_valid changes nothing; start=1 → new gen_start pulse, score=0, lose=0.
- All 9 items guessed correctly through level 9 → win=1, score=9, level stays 9.
- INPUT with no guess: lose asserts on the TIMEOUT_TICKS-th tick. guess_valid (correct) in that same cycle → accepted, no lose. Resetn pulse during SHOW → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/memory_game_sequencer_if.sv
// Signal bundle between the memory-game play controller and its environment:
// time base, start/restart, generator + memory read port, player input and display.
interface memory_game_sequencer_if;
    logic       tick;
    logic       start;
    logic       gen_done;
    logic [3:0] mem_data;
    logic [3:0] guess;
    logic       guess_valid;
    logic       gen_start;
    logic [3:0] read_add;
    logic [3:0] show_val;
    logic       show_en;
    logic [3:0] level;
    logic [3:0] score;
    logic       busy;
    logic       win;
    logic       lose;

    modport master (
        output tick, start, gen_done, mem_data, guess, guess_valid,
        input  gen_start, read_add, show_val, show_en, level, score, busy, win, lose
    );

    modport slave (
        input  tick, start, gen_done, mem_data, guess, guess_valid,
        output gen_start, read_add, show_val, show_en, level, score, busy, win, lose
    );
endinterface

// File: rtl/memory_game_sequencer.sv
// Memory-game play controller: triggers sequence generation, replays a growing
// prefix of the stored sequence, checks player guesses and tracks level/score.
module memory_game_sequencer #(
    parameter int unsigned N_ITEMS       = 9,
    parameter int unsigned SHOW_TICKS    = 50,
    parameter int unsigned GAP_TICKS     = 10,
    parameter int unsigned TIMEOUT_TICKS = 255
) (
    input  logic                   clock,
    input  logic                   Resetn,
    memory_game_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_GEN = 3'd1,
        SHOW     = 3'd2,
        GAP      = 3'd3,
        INPUT    = 3'd4,
        WIN      = 3'd5,
        LOSE     = 3'd6
    } state_t;

    localparam logic [3:0] LAST_LEVEL   = 4'(N_ITEMS);
    localparam logic [7:0] SHOW_LAST    = 8'(SHOW_TICKS - 1);
    localparam logic [7:0] GAP_LAST     = 8'(GAP_TICKS - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_TICKS - 1);

    state_t     state_r;
    logic [7:0] tickCnt_r;
    logic [7:0] timeout_r;
    logic [3:0] idx_r;
    logic       holdOff_r;
    logic       genStart_r;
    logic [3:0] readAdd_r;
    logic [3:0] showVal_r;
    logic       showEn_r;
    logic [3:0] level_r;
    logic [3:0] score_r;
    logic       busy_r;
    logic       win_r;
    logic       lose_r;

    // holdOff_r blocks the cycle where read_add still points at the previous item
    logic guessTake_s;
    logic guessOk_s;
    assign guessTake_s = bus.guess_valid && !holdOff_r;
    assign guessOk_s   = (bus.guess == bus.mem_data);

    assign bus.gen_start = genStart_r;
    assign bus.read_add  = readAdd_r;
    assign bus.show_val  = showVal_r;
    assign bus.show_en   = showEn_r;
    assign bus.level     = level_r;
    assign bus.score     = score_r;
    assign bus.busy      = busy_r;
    assign bus.win       = win_r;
    assign bus.lose      = lose_r;

    // Play controller: state, counters and every registered output.
    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r    <= IDLE;
            tickCnt_r  <= 8'd0;
            timeout_r  <= 8'd0;
            idx_r      <= 4'd0;
            holdOff_r  <= 1'b0;
            genStart_r <= 1'b0;
            readAdd_r  <= 4'd0;
            showVal_r  <= 4'd0;
            showEn_r   <= 1'b0;
            level_r    <= 4'd0;
            score_r    <= 4'd0;
            busy_r     <= 1'b0;
            win_r      <= 1'b0;
            lose_r     <= 1'b0;
        end else begin
            genStart_r <= 1'b0;
            holdOff_r  <= 1'b0;
            case (state_r)
                IDLE, WIN, LOSE: begin
                    if (bus.start) begin
                        score_r    <= 4'd0;
                        win_r      <= 1'b0;
                        lose_r     <= 1'b0;
                        level_r    <= 4'd1;
                        idx_r      <= 4'd0;
                        tickCnt_r  <= 8'd0;
                        genStart_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= WAIT_GEN;
                    end
                end
                WAIT_GEN: begin
                    // a done level left over from the last game is ignored while gen_start is out
                    if (bus.gen_done && !genStart_r) begin
                        idx_r     <= 4'd0;
                        readAdd_r <= 4'd0;
                        tickCnt_r <= 8'd0;
                        state_r   <= SHOW;
                    end
                end
                SHOW: begin
                    readAdd_r <= idx_r;
                    if (bus.tick && (tickCnt_r == SHOW_LAST)) begin
                        tickCnt_r <= 8'd0;
                        showEn_r  <= 1'b0;
                        showVal_r <= 4'd0;
                        state_r   <= GAP;
                    end else begin
                        if (bus.tick) begin
                            tickCnt_r <= tickCnt_r + 8'd1;
                        end
                        showEn_r  <= 1'b1;
                        showVal_r <= bus.mem_data;
                    end
                end
                GAP: begin
                    if (bus.tick) begin
                        if (tickCnt_r == GAP_LAST) begin
                            tickCnt_r <= 8'd0;
                            if ((idx_r + 4'd1) == level_r) begin
                                idx_r     <= 4'd0;
                                readAdd_r <= 4'd0;
                                timeout_r <= 8'd0;
                                state_r   <= INPUT;
                            end else begin
                                idx_r     <= idx_r + 4'd1;
                                readAdd_r <= idx_r + 4'd1;
                                state_r   <= SHOW;
                            end
                        end else begin
                            tickCnt_r <= tickCnt_r + 8'd1;
                        end
                    end
                end
                INPUT: begin
                    readAdd_r <= idx_r;
                    showEn_r  <= 1'b0;
                    if (guessTake_s) begin
                        timeout_r <= 8'd0;
                        if (!guessOk_s) begin
                            lose_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= LOSE;
                        end else if ((idx_r + 4'd1) < level_r) begin
                            idx_r     <= idx_r + 4'd1;
                            holdOff_r <= 1'b1;
                        end else begin
                            if (score_r < LAST_LEVEL) begin
                                score_r <= score_r + 4'd1;
                            end
                            if (level_r >= LAST_LEVEL) begin
                                win_r   <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= WIN;
                            end else begin
                                level_r   <= level_r + 4'd1;
                                idx_r     <= 4'd0;
                                readAdd_r <= 4'd0;
                                tickCnt_r <= 8'd0;
                                state_r   <= SHOW;
                            end
                        end
                    end else if (bus.tick) begin
                        if (timeout_r == TIMEOUT_LAST) begin
                            lose_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= LOSE;
                        end else begin
                            timeout_r <= timeout_r + 8'd1;
                        end
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_game_sequencer.sv
// Bench for memory_game_sequencer: a table of fixed games, random games scored by
// the game rules, and hand-written sequences for the timing corner cases.
module tb_memory_game_sequencer;
    localparam int NI   = 9;
    localparam int ST   = 2;
    localparam int GT   = 1;
    localparam int TO   = 6;
    localparam int TDIV = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    memory_game_sequencer_if gif();

    memory_game_sequencer #(
        .N_ITEMS(NI), .SHOW_TICKS(ST), .GAP_TICKS(GT), .TIMEOUT_TICKS(TO)
    ) dut (
        .clock (clk),
        .Resetn(rstn),
        .bus   (gif.slave)
    );

    logic [3:0] mem [16];
    assign gif.mem_data = mem[gif.read_add];

    typedef struct {
        int failLevel;   // 0 = play through to a win
        int failIdx;
        bit toFail;      // fail by timeout instead of a wrong guess
        int expScore;
        int expLevel;
        int expWin;
        int expLose;
    } game_t;

    game_t tbl [4];
    int vecs = 0;
    int errs = 0;
    int blankBad = 0;
    logic [3:0] shown [$];
    logic prevEn = 1'b0;

    // Display monitor: one entry per show_en rising edge, and blank-value checking.
    always @(negedge clk) begin
        if (gif.show_en && !prevEn) shown.push_back(gif.show_val);
        if (!gif.show_en && (gif.show_val != 4'd0)) blankBad <= blankBad + 1;
        prevEn <= gif.show_en;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, int act, int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        gif.tick        = 1'b0;
        gif.guess_valid = 1'b0;
        gif.start       = 1'b0;
    endtask

    task automatic tickCyc();
        gif.tick = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic sendGuess(logic [3:0] g);
        gif.guess       = g;
        gif.guess_valid = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic startGame();
        gif.gen_done = 1'b0;
        gif.start    = 1'b1;
        cyc();
        cyc();
        gif.gen_done = 1'b1;
    endtask

    // Runs the free time base until `target` values have been shown and the last one has blanked.
    task automatic waitShows(int target);
        int budget = 4000;
        int div = 0;
        while (!((shown.size() >= target) && !gif.show_en) && (budget > 0)) begin
            if (div == TDIV - 1) gif.tick = 1'b1;
            div = (div + 1) % TDIV;
            cyc();
            budget--;
        end
        if (budget == 0) begin
            vecs++;
            errs++;
            $display("FAIL show_wait: shown %0d values, required %0d", shown.size(), target);
        end
    endtask

    task automatic enterInput();
        repeat (GT) tickCyc();
        check("input_read_add", int'(gif.read_add), 0);
    endtask

    task automatic checkShown(logic [3:0] expSeq [$]);
        check("shown_count", shown.size(), expSeq.size());
        for (int i = 0; i < expSeq.size() && i < shown.size(); i++)
            check("shown_val", int'(shown[i]), int'(expSeq[i]));
    endtask

    task automatic playGame(game_t g, bit fresh);
        int lastL;
        logic [3:0] expSeq [$];
        lastL = (g.failLevel == 0) ? NI : g.failLevel;
        if (fresh) begin
            shown.delete();
            startGame();
        end
        for (int L = 1; L <= lastL; L++) begin
            for (int i = 0; i < L; i++) expSeq.push_back(mem[i]);
            waitShows(expSeq.size());
            check("level_in_play", int'(gif.level), L);
            enterInput();
            for (int i = 0; i < L; i++) begin
                if ((L == g.failLevel) && (i == g.failIdx)) begin
                    if (g.toFail) repeat (TO) tickCyc();
                    else sendGuess(mem[i] + 4'd1);
                    break;
                end
                sendGuess(mem[i]);
            end
        end
        cyc();
        check("final_score", int'(gif.score), g.expScore);
        check("final_level", int'(gif.level), g.expLevel);
        check("final_win",   int'(gif.win),   g.expWin);
        check("final_lose",  int'(gif.lose),  g.expLose);
        check("final_busy",  int'(gif.busy),  0);
        checkShown(expSeq);
    endtask

    task automatic checkResetOutputs(string tag);
        check({tag, "_read_add"},  int'(gif.read_add),  0);
        check({tag, "_show_val"},  int'(gif.show_val),  0);
        check({tag, "_show_en"},   int'(gif.show_en),   0);
        check({tag, "_level"},     int'(gif.level),     0);
        check({tag, "_score"},     int'(gif.score),     0);
        check({tag, "_gen_start"}, int'(gif.gen_start), 0);
        check({tag, "_busy"},      int'(gif.busy),      0);
        check({tag, "_win"},       int'(gif.win),       0);
        check({tag, "_lose"},      int'(gif.lose),      0);
    endtask

    initial begin
        logic [3:0] preset [9] = '{4'd3, 4'd7, 4'd1, 4'd8, 4'd2, 4'd9, 4'd4, 4'd6, 4'd5};
        game_t rg;
        int budget;

        tbl[0] = '{failLevel: 0, failIdx: 0, toFail: 1'b0, expScore: 9, expLevel: 9, expWin: 1, expLose: 0};
        tbl[1] = '{failLevel: 2, failIdx: 1, toFail: 1'b0, expScore: 1, expLevel: 2, expWin: 0, expLose: 1};
        tbl[2] = '{failLevel: 1, failIdx: 0, toFail: 1'b1, expScore: 0, expLevel: 1, expWin: 0, expLose: 1};
        tbl[3] = '{failLevel: 5, failIdx: 4, toFail: 1'b0, expScore: 4, expLevel: 5, expWin: 0, expLose: 1};

        for (int i = 0; i < 16; i++) mem[i] = (i < NI) ? preset[i] : 4'd0;
        gif.tick = 1'b0; gif.start = 1'b0; gif.gen_done = 1'b0;
        gif.guess = 4'd0; gif.guess_valid = 1'b0;

        // Reset state, single-cycle gen_start, WAIT_GEN holds while gen_done is low
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        cyc();
        checkResetOutputs("reset");
        gif.start = 1'b1;
        cyc();
        check("start_gen_start", int'(gif.gen_start), 1);
        check("start_level",     int'(gif.level),     1);
        check("start_busy",      int'(gif.busy),      1);
        cyc();
        check("gen_start_width", int'(gif.gen_start), 0);
        repeat (20) cyc();
        check("wait_gen_busy",    int'(gif.busy),    1);
        check("wait_gen_show_en", int'(gif.show_en), 0);
        check("wait_gen_level",   int'(gif.level),   1);

        // Preset memory, full game to a win
        gif.gen_done = 1'b1;
        shown.delete();
        playGame(tbl[0], 1'b0);

        // Restart from WIN with gen_done still high: it is not taken while gen_start is out
        shown.delete();
        gif.start = 1'b1;
        cyc();
        check("restart_gen_start", int'(gif.gen_start), 1);
        check("restart_win",       int'(gif.win),       0);
        check("restart_score",     int'(gif.score),     0);
        cyc();
        cyc();
        check("gen_done_gated", int'(gif.show_en), 0);
        cyc();
        check("show_after_gen", int'(gif.show_en), 1);
        playGame(tbl[1], 1'b0);

        for (int t = 2; t < 4; t++) playGame(tbl[t], 1'b1);

        // Hand sequence: ignored start, post-accept hold cycle, guess-vs-timeout priority, timeout, dead guess
        shown.delete();
        startGame();
        check("restart_lose", int'(gif.lose), 0);
        waitShows(1);
        enterInput();
        sendGuess(mem[0]);
        waitShows(3);
        enterInput();
        gif.start = 1'b1;
        cyc();
        check("start_ignored_gen", int'(gif.gen_start), 0);
        check("start_ignored_lvl", int'(gif.level),     2);
        gif.guess = mem[0]; gif.guess_valid = 1'b1;
        cyc();
        gif.guess = mem[1] + 4'd1; gif.guess_valid = 1'b1;
        cyc();
        cyc();
        check("hold_guess_ignored", int'(gif.lose), 0);
        repeat (TO - 1) tickCyc();
        gif.tick = 1'b1; gif.guess = mem[1]; gif.guess_valid = 1'b1;
        cyc();
        cyc();
        check("priority_lose",  int'(gif.lose),  0);
        check("priority_score", int'(gif.score), 2);
        check("priority_level", int'(gif.level), 3);
        waitShows(6);
        enterInput();
        repeat (TO - 1) tickCyc();
        check("timeout_early", int'(gif.lose), 0);
        gif.tick = 1'b1;
        cyc();
        check("timeout_lose", int'(gif.lose), 1);
        check("timeout_busy", int'(gif.busy), 0);
        sendGuess(mem[0]);
        check("dead_guess_lose",  int'(gif.lose),  1);
        check("dead_guess_score", int'(gif.score), 2);

        // Random games scored by the game rules
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < NI; i++) mem[i] = 4'($urandom_range(0, 15));
            rg.failLevel = $urandom_range(0, NI);
            rg.failIdx   = (rg.failLevel > 0) ? $urandom_range(0, rg.failLevel - 1) : 0;
            rg.toFail    = 1'($urandom_range(0, 1));
            rg.expWin    = (rg.failLevel == 0) ? 1 : 0;
            rg.expLose   = 1 - rg.expWin;
            rg.expScore  = (rg.failLevel == 0) ? NI : rg.failLevel - 1;
            rg.expLevel  = (rg.failLevel == 0) ? NI : rg.failLevel;
            playGame(rg, 1'b1);
        end

        // Reset in the middle of SHOW acts immediately and does not re-trigger the generator
        startGame();
        budget = 50;
        while (!gif.show_en && (budget > 0)) begin
            cyc();
            budget--;
        end
        check("reached_show", int'(gif.show_en), 1);
        #3 rstn = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        #2 rstn = 1'b1;
        repeat (5) cyc();
        check("post_reset_gen_start", int'(gif.gen_start), 0);
        check("post_reset_busy",      int'(gif.busy),      0);

        check("blank_show_val", blankBad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
